// File: rtl/rv32i_pkg.sv
// Shared RV32I control-flow definitions.
//   - Branch funct3 encodings used by the taken decision.
//   - fetch_state_t: states of the single-outstanding fetch handshake.
//   - RESET_PC_DEFAULT: default first fetch address after reset.
package rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/branch_decide.sv
// Combinational branch resolution from the comparator results.
// Ports:
//   funct3  in  3  branch funct3
//   br_eq   in  1  comparator equality result
//   br_lt   in  1  comparator less-than result
//   taken   out 1  branch condition holds (ignores valid / is_branch)
//   br_un   out 1  unsigned-compare select back to the comparator
module branch_decide
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       br_un
);

  // funct3[1] distinguishes BLTU/BGEU from BLT/BGE.
  assign br_un = funct3[1];

  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      F3_BEQ:            taken = br_eq;
      F3_BNE:            taken = ~br_eq;
      F3_BLT, F3_BLTU:   taken = br_lt;
      F3_BGE, F3_BGEU:   taken = ~br_lt;
      default:           taken = 1'b0;  // 010/011 are not branches
    endcase
  end

endmodule

// File: rtl/branch_fetch_ctrl.sv
// Control-flow stage: resolves branches/jumps, owns the PC, runs a
// single-outstanding fetch handshake and presents instructions to decode.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   ex_valid/ex_is_branch/ex_is_jump/ex_funct3/ex_target  execute-stage info
//   BrEq, BrLt (in) / BrUn (out) branch comparator interface
//   redirect                     PCSel, taken and aligned this cycle
//   misalign_err                 taken target has bit 1 set (pulse)
//   imem_req_valid/ready, imem_addr          fetch request channel
//   imem_rsp_valid, imem_rsp_data            fetch response channel
//   if_valid/if_ready, if_inst, if_pc        decode handoff
module branch_fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [2:0]      ex_funct3,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic            BrUn,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect,
  output logic            misalign_err,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            kill_q, kill_d;

  logic            br_taken;
  logic            take;
  logic [XLEN-1:0] final_target;
  logic            accept;

  branch_decide u_branch_decide (
    .funct3 (ex_funct3),
    .br_eq  (BrEq),
    .br_lt  (BrLt),
    .taken  (br_taken),
    .br_un  (BrUn)
  );

  assign take = ex_valid & (ex_is_jump | (ex_is_branch & br_taken));

  // JALR clears bit 0 of the computed target; branches use it unchanged.
  assign final_target = ex_is_jump ? {ex_target[XLEN-1:1], 1'b0} : ex_target;

  // A misaligned taken target suppresses the redirect entirely.
  assign misalign_err = rst_n & take & final_target[1];
  assign redirect     = take & ~final_target[1];

  // Request is masked while reset is held so nothing leaks out of reset.
  assign imem_req_valid = rst_n & (state_q == FETCH);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  assign if_valid = (state_q == HOLD);
  assign if_inst  = if_inst_q;
  assign if_pc    = if_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    fetch_pc_d = fetch_pc_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      FETCH: begin
        if (accept) begin
          state_d    = WAIT;
          fetch_pc_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
          // Request already issued on the wrong path: drop its response.
          kill_d     = redirect;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect) begin
            state_d = FETCH;
          end else begin
            if_inst_d = imem_rsp_data;
            if_pc_d   = fetch_pc_q;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || if_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (redirect) begin
      pc_d = final_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      fetch_pc_q <= '0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      fetch_pc_q <= fetch_pc_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule
